// File: rtl/rect_track_pkg.sv
// rect_track_pkg: shared types, widths and helpers for the bounding-box track filter
package rect_track_pkg;
  localparam int COORD_W = 11;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, HOLD = 2'd3} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/rect_edge_filter.sv
// rect_edge_filter: one box edge with snap-on-jump IIR smoothing and range clamp
module rect_edge_filter import rect_track_pkg::*; #(
  parameter int ALPHA_SHIFT = 2,
  parameter logic [COORD_W-1:0] MAX_JUMP = 11'd200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] raw,
  input  logic [COORD_W-1:0] current,
  input  logic [COORD_W-1:0] limit,
  input  logic               load,
  input  logic               update,
  output logic [COORD_W-1:0] value
);
  localparam logic signed [COORD_W:0] MJ = $signed({1'b0, MAX_JUMP});
  logic signed [COORD_W:0] r, c, d, ad, f, lim1;
  logic [COORD_W-1:0] nxt;
  always_comb begin
    r = $signed({1'b0, raw});
    c = $signed({1'b0, current});
    d = r - c;
    ad = (d < 0) ? -d : d;
    f = (load || ad > MJ) ? r : c + (d >>> ALPHA_SHIFT);
    lim1 = $signed({1'b0, limit}) - 12'sd1;
    nxt = (f < 0) ? '0 : (f > lim1) ? lim1[COORD_W-1:0] : f[COORD_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (load || update) value <= nxt;
endmodule

// File: rtl/rect_track_filter.sv
// rect_track_filter: per-frame presence hysteresis and edge smoothing of the detector box
module rect_track_filter import rect_track_pkg::*; #(
  parameter logic [COORD_W-1:0] IMG_HDISP = 11'd960,
  parameter logic [COORD_W-1:0] IMG_VDISP = 11'd540,
  parameter int ALPHA_SHIFT = 2,
  parameter int ON_FRAMES = 3,
  parameter int OFF_FRAMES = 5,
  parameter logic [COORD_W-1:0] MAX_JUMP = 11'd200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               per_frame_vsync,
  input  logic [COORD_W-1:0] rectangular_up,
  input  logic [COORD_W-1:0] rectangular_down,
  input  logic [COORD_W-1:0] rectangular_left,
  input  logic [COORD_W-1:0] rectangular_right,
  input  logic               flag,
  output logic [COORD_W-1:0] box_up,
  output logic [COORD_W-1:0] box_down,
  output logic [COORD_W-1:0] box_left,
  output logic [COORD_W-1:0] box_right,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic               box_valid,
  output logic               update_pulse
);
  localparam logic [CNT_W-1:0] ON_N = CNT_W'(ON_FRAMES);
  localparam logic [CNT_W-1:0] OFF_N = CNT_W'(OFF_FRAMES);
  state_t state, st_n;
  logic vs_d, bnd, smp_v, s_hit, ld, upd, clr;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, hit_n, miss_n;
  logic [COORD_W-1:0] s_up, s_down, s_left, s_right, f_up, f_down, f_left, f_right;
  logic [COORD_W:0] sum_x, sum_y;
  // vs_d resets high so a sync already asserted at reset release is not a boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_d <= 1'b1;
      bnd <= 1'b0;
      smp_v <= 1'b0;
      update_pulse <= 1'b0;
      s_hit <= 1'b0;
      {s_up, s_down, s_left, s_right} <= '0;
      state <= IDLE;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      vs_d <= per_frame_vsync;
      bnd <= per_frame_vsync && !vs_d;
      smp_v <= bnd;
      update_pulse <= smp_v;
      if (bnd) begin
        s_hit <= flag && rectangular_left < rectangular_right && rectangular_up < rectangular_down;
        {s_up, s_down, s_left, s_right} <= {rectangular_up, rectangular_down, rectangular_left, rectangular_right};
      end
      if (smp_v) begin
        state <= st_n;
        hit_cnt <= hit_n;
        miss_cnt <= miss_n;
      end
    end
  always_comb begin
    st_n = state;
    hit_n = hit_cnt;
    miss_n = miss_cnt;
    ld = 1'b0;
    upd = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE: if (s_hit) begin
        ld = 1'b1;
        hit_n = 4'd1;
        st_n = (ON_N == 4'd1) ? TRACK : ACQUIRE;
      end
      ACQUIRE: if (s_hit) begin
        upd = 1'b1;
        hit_n = sat_inc(hit_cnt);
        st_n = (hit_n >= ON_N) ? TRACK : ACQUIRE;
      end else clr = 1'b1;
      TRACK: if (s_hit) upd = 1'b1;
      else begin
        miss_n = 4'd1;
        clr = (OFF_N == 4'd1);
        st_n = clr ? IDLE : HOLD;
      end
      HOLD: if (s_hit) begin
        miss_n = '0;
        upd = 1'b1;
        st_n = TRACK;
      end else begin
        miss_n = sat_inc(miss_cnt);
        clr = (miss_n >= OFF_N);
        st_n = clr ? IDLE : HOLD;
      end
      default: st_n = IDLE;
    endcase
    if (clr) begin
      st_n = IDLE;
      hit_n = '0;
      miss_n = '0;
    end
  end
  rect_edge_filter #(.ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)) u_up (
    .clk(clk), .rst_n(rst_n), .raw(clr ? '0 : s_up), .current(box_up), .limit(IMG_VDISP),
    .load(smp_v && (ld || clr)), .update(smp_v && upd), .value(f_up));
  rect_edge_filter #(.ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)) u_down (
    .clk(clk), .rst_n(rst_n), .raw(clr ? '0 : s_down), .current(box_down), .limit(IMG_VDISP),
    .load(smp_v && (ld || clr)), .update(smp_v && upd), .value(f_down));
  rect_edge_filter #(.ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)) u_left (
    .clk(clk), .rst_n(rst_n), .raw(clr ? '0 : s_left), .current(box_left), .limit(IMG_HDISP),
    .load(smp_v && (ld || clr)), .update(smp_v && upd), .value(f_left));
  rect_edge_filter #(.ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)) u_right (
    .clk(clk), .rst_n(rst_n), .raw(clr ? '0 : s_right), .current(box_right), .limit(IMG_HDISP),
    .load(smp_v && (ld || clr)), .update(smp_v && upd), .value(f_right));
  // ordering is applied on the registered edges, so the filters track the ordered box
  always_comb begin
    box_left = (f_left > f_right) ? f_right : f_left;
    box_right = (f_left > f_right) ? f_left : f_right;
    box_up = (f_up > f_down) ? f_down : f_up;
    box_down = (f_up > f_down) ? f_up : f_down;
    sum_x = {1'b0, box_left} + {1'b0, box_right};
    sum_y = {1'b0, box_up} + {1'b0, box_down};
    center_x = sum_x[COORD_W:1];
    center_y = sum_y[COORD_W:1];
    box_valid = (state == TRACK) || (state == HOLD);
  end
endmodule

// File: doc/rect_track_filter.md
# rect_track_filter

Temporal stabiliser for the human-detection bounding box. Sits directly downstream of the rectangle detector (binarize → erosion → dilation → detect_rectangular) and upstream of the rectangle overlay/coordinate output. Once per frame it samples the detector's raw box and applies presence hysteresis and per-edge IIR smoothing. It outputs a steady box, its centre and a valid flag, so the overlay does not flicker or jump on single-frame noise.

## Interface
Parameters:
- IMG_HDISP, 11'd960: active width; x outputs clamped to [0, IMG_HDISP-1]
- IMG_VDISP, 11'd540: active height; y outputs clamped to [0, IMG_VDISP-1]
- ALPHA_SHIFT, 2: IIR gain = 1/2^ALPHA_SHIFT, legal 0..4
- ON_FRAMES, 3: consecutive hits needed to declare presence, legal 1..15
- OFF_FRAMES, 5: consecutive misses needed to drop the track, legal 1..15
- MAX_JUMP, 11'd200: per-edge jump above which the filter snaps to the raw value

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: pixel clock, shared with the detector
  - rst_n, in, 1: asynchronous active-low reset
- per_frame_vsync, in, 1: detector frame sync; active-high
- rectangular_up, in, 11: raw box top edge
- rectangular_down, in, 11: raw box bottom edge
- rectangular_left, in, 11: raw box left edge
- rectangular_right, in, 11: raw box right edge
- flag, in, 1: detector found a target
- box_up, out, 11: smoothed box top edge
- box_down, out, 11: smoothed box bottom edge
- box_left, out, 11: smoothed box left edge
- box_right, out, 11: smoothed box right edge
- center_x, out, 11: (box_left+box_right)>>1, 12-bit sum then truncated
- center_y, out, 11: (box_up+box_down)>>1, same width rule
- box_valid, out, 1: high in TRACK or HOLD
- update_pulse, out, 1: one-cycle strobe when outputs change

## Operation
- Frame boundary: rising edge of per_frame_vsync, detected against a registered copy vs_d.
  - vs_d resets to 1, so a sync already high at reset release is not an edge.
- Hit: flag=1 && left<right && up<down. Anything else is a miss.
- Raw inputs are sampled only on the boundary. They are ignored at all other times.
- FSM states: IDLE, ACQUIRE, TRACK, HOLD. Reset state is IDLE. One transition per boundary.
- IDLE:
  - Hit: load raw into the box, hit_cnt=1, go to ACQUIRE. If ON_FRAMES==1, go straight to TRACK.
  - Miss: stay in IDLE.
- ACQUIRE:
  - Hit: hit_cnt+1 and the box is filtered. When hit_cnt reaches ON_FRAMES, go to TRACK.
  - Miss: go to IDLE and zero the box.
- TRACK:
  - Hit: filter the box.
  - Miss: miss_cnt=1, box held, go to HOLD. If OFF_FRAMES==1, go straight to IDLE.
- HOLD:
  - Hit: miss_cnt=0, filter the box, go to TRACK.
  - Miss: miss_cnt+1. When it reaches OFF_FRAMES, go to IDLE and zero the box.
- Per-edge filter, computed in 12-bit signed:
  - d = raw - f.
  - If |d| > MAX_JUMP: f = raw (snap).
  - Otherwise: f = f + (d >>> ALPHA_SHIFT), arithmetic shift, truncating toward -inf.
  - Result is clamped to [0, IMG_*DISP-1].
- Ordering after the filter: if box_left > box_right, swap them. Same rule for up/down.
- Counters saturate at 15.

## Timing
- Let E be the clock edge at which vsync=1 and vs_d=0.
  - Edge E+1: raw inputs sampled.
  - Edge E+2: state, box_*, center_*, box_valid update, and update_pulse goes high for exactly one cycle.
- update_pulse fires on every boundary, including misses and IDLE→IDLE.
- Outputs are constant between update_pulses.
- A new edge arriving during E+1/E+2 is a legal boundary and is processed in order. Frames are never shorter than 3 clocks.
- Reset at any time: all outputs 0, state IDLE, counters 0, vs_d=1. Reset takes effect asynchronously; outputs are zero on the next sampled cycle.

## Structure
- Shared package/header rect_track_pkg holds:
  - state encoding (IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3)
  - COORD_W=11
  - counter width 4
- Sub-module rect_edge_filter, instantiated four times:
  - inputs: raw, current, limit, load, update
  - output: next value
  - contains the snap/IIR/clamp logic; purely combinational plus one output register
- Top level contains:
  - edge detect
  - sample registers
  - FSM and counters
  - swap/order logic
  - centre adders

## Test plan
- Acquire: ON_FRAMES=3; 3 frames of hits with box (100,200,300,400) as up/down/left/right.
  - box_valid rises at the third pulse.
  - center_x=350, center_y=150.
- Smoothing: in TRACK with left=300, raw left=340, ALPHA_SHIFT=2.
  - left becomes 310, then 317 on the next frame.
  - update_pulse occurs at E+2.
- Snap: in TRACK with left=300, raw left=700.
  - left becomes 700 in one frame.
- Dropout:
  - 4 misses: box held, box_valid=1. A hit then returns the FSM to TRACK.
  - 5 misses: IDLE, box_valid=0, box zeroed.
- Invalid/clamp:
  - flag=1 with left=500, right=400: treated as a miss; ACQUIRE→IDLE.
  - raw right=1023: clamped to 959.
- Reset: assert rst_n mid-HOLD with vsync high.
  - All outputs go to 0.
  - No update_pulse until the next genuine vsync rising edge.
